// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder blocks: block-alignment states,
// block-size helpers and a variable-width bit-reversal function.
package fft_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        FILL      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int MAX_LG = 32;

    function automatic int fft_n(input int lg);
        return 1 << lg;
    endfunction

    function automatic int fft_n2(input int lg);
        return fft_n(lg) / 2;
    endfunction

    function automatic int fft_n4(input int lg);
        return fft_n(lg) / 4;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_LG-1:0] br(input logic [MAX_LG-1:0] v, input int w);
        logic [MAX_LG-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_LG; i++) begin
            if (i < w) res[w-1-i] = v[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/unbitrev_bank.sv
// One-write, two-read sample memory with registered read ports, used as one
// lane of the unbitreverse ping-pong buffer.
module unbitrev_bank
    import fft_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 48
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr_0,
    input  logic [AW-1:0] i_raddr_1,
    output logic [DW-1:0] o_rdata_0,
    output logic [DW-1:0] o_rdata_1
);

    logic [DW-1:0] r_mem [2**AW];

    // NOTE: the storage array has no reset, so it maps onto plain RAM; only the read registers clear.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rdata_0 <= '0;
            o_rdata_1 <= '0;
        end else if (i_re) begin
            o_rdata_0 <= r_mem[i_raddr_0];
            o_rdata_1 <= r_mem[i_raddr_1];
        end
    end

endmodule

// File: rtl/unbitreverse.sv
// Converts a two-sample-per-clock bit-reversed FFT block back to natural order
// using ping-pong buffering. Define UNBITREVERSE_RESYNC_EN to realign on a stray sync.
module unbitreverse
    import fft_pkg::*;
#(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_sync,
    input  logic [2*WIDTH-1:0] i_in_0,
    input  logic [2*WIDTH-1:0] i_in_1,
    output logic [2*WIDTH-1:0] o_out_0,
    output logic [2*WIDTH-1:0] o_out_1,
    output logic             o_valid,
    output logic             o_sync,
    output logic             o_err
);

    localparam int N  = fft_n(LGSIZE);
    localparam int N2 = fft_n2(LGSIZE);
    localparam int N4 = fft_n4(LGSIZE);
    localparam int CW = LGSIZE - 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] C_LAST = CW'(N2 - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_c, w_c_nxt;
    logic          r_pp, w_pp_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_sync, w_sync_nxt;
    logic          r_lane;

    logic          w_resync;
    logic          w_we;
    logic          w_rd_en;
    logic [CW-1:0] w_wr_c;
    logic [CW-1:0] w_r;
    logic [LGSIZE-1:0] w_waddr, w_raddr_0, w_raddr_1;
    logic [DW-1:0] w_a_rd0, w_a_rd1, w_b_rd0, w_b_rd1;

`ifdef UNBITREVERSE_RESYNC_EN
    assign w_resync = i_ce && i_sync && (r_state != WAIT_SYNC) && (r_c != '0);
`else
    assign w_resync = 1'b0;
`endif

    assign w_we    = i_ce && ((r_state != WAIT_SYNC) || i_sync);
    assign w_rd_en = i_ce && (r_state == RUN);
    assign w_wr_c  = w_resync ? '0 : r_c;
    assign w_waddr = {r_pp, w_wr_c};

    // Output step c needs X[2c], X[2c+1]: both sit in lane c[MSB], N/4 words apart.
    assign w_r       = CW'(br(MAX_LG'({r_c, 1'b0}), LGSIZE) >> 1);
    assign w_raddr_0 = {~r_pp, w_r};
    assign w_raddr_1 = {~r_pp, w_r + CW'(N4)};

    always_comb begin
        // NOTE: each next-state signal is given its hold value first, so no latch is inferred.
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_pp_nxt    = r_pp;
        w_valid_nxt = r_valid;
        w_sync_nxt  = r_sync;
        if (i_ce) begin
            unique case (r_state)
                WAIT_SYNC: begin
                    if (i_sync) begin
                        w_c_nxt     = CW'(1);
                        w_state_nxt = FILL;
                    end
                end
                FILL: begin
                    if (r_c == C_LAST) begin
                        w_c_nxt     = '0;
                        w_pp_nxt    = ~r_pp;
                        w_state_nxt = RUN;
                    end else begin
                        w_c_nxt = r_c + CW'(1);
                    end
                end
                RUN: begin
                    w_valid_nxt = 1'b1;
                    w_sync_nxt  = (r_c == '0);
                    w_c_nxt     = r_c + CW'(1);
                    if (r_c == C_LAST) w_pp_nxt = ~r_pp;
                end
                default: w_state_nxt = WAIT_SYNC;
            endcase
            if (w_resync) begin
                w_c_nxt     = CW'(1);
                w_state_nxt = FILL;
                w_valid_nxt = 1'b0;
                w_sync_nxt  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= WAIT_SYNC;
            r_c     <= '0;
            r_pp    <= 1'b0;
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
            r_lane  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_pp    <= w_pp_nxt;
            r_valid <= w_valid_nxt;
            r_sync  <= w_sync_nxt;
            if (w_rd_en) r_lane <= r_c[CW-1];
        end
    end

`ifdef UNBITREVERSE_RESYNC_EN
    logic r_err;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   r_err <= 1'b0;
        else if (i_ce) r_err <= w_resync;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    unbitrev_bank #(.AW(LGSIZE), .DW(DW)) u_bank_a (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (i_in_0),
        .i_re      (w_rd_en),
        .i_raddr_0 (w_raddr_0),
        .i_raddr_1 (w_raddr_1),
        .o_rdata_0 (w_a_rd0),
        .o_rdata_1 (w_a_rd1)
    );

    unbitrev_bank #(.AW(LGSIZE), .DW(DW)) u_bank_b (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (i_in_1),
        .i_re      (w_rd_en),
        .i_raddr_0 (w_raddr_0),
        .i_raddr_1 (w_raddr_1),
        .o_rdata_0 (w_b_rd0),
        .o_rdata_1 (w_b_rd1)
    );

    assign o_out_0 = r_lane ? w_b_rd0 : w_a_rd0;
    assign o_out_1 = r_lane ? w_b_rd1 : w_a_rd1;
    assign o_valid = r_valid;
    assign o_sync  = r_sync;

endmodule

// File: tb/tb_unbitreverse.sv
// Self-checking bench for unbitreverse at LGSIZE=4, WIDTH=8: hand-written
// reorder table plus a block-framing scoreboard.
module tb_unbitreverse;

    localparam int LG = 4;
    localparam int W  = 8;
    localparam int N2 = 8;
    localparam int DW = 2 * W;
`ifdef UNBITREVERSE_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          sync = 1'b0;
    logic [DW-1:0] in0 = '0;
    logic [DW-1:0] in1 = '0;
    logic [DW-1:0] out0, out1;
    logic          valid, osync, err;

    always #5 clk = ~clk;

    unbitreverse #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (ce),
        .i_sync  (sync),
        .i_in_0  (in0),
        .i_in_1  (in1),
        .o_out_0 (out0),
        .o_out_1 (out1),
        .o_valid (valid),
        .o_sync  (osync),
        .o_err   (err)
    );

    typedef struct {
        int in0_idx;
        int in1_idx;
        int out0_idx;
        int out1_idx;
    } vec_t;

    typedef struct {
        logic [DW-1:0] o0;
        logic [DW-1:0] o1;
        logic          s;
    } exp_t;

    vec_t          tbl[N2];
    exp_t          sb[$];
    exp_t          last_exp;
    bit            have_last = 1'b0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            err_pulses = 0;

    logic [DW-1:0] m_feed0[N2];
    logic [DW-1:0] m_feed1[N2];
    int            m_cnt = 0;
    bit            m_armed = 1'b0;
    bit            m_real = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [DW-1:0] val(input int blk, input int k);
        logic [7:0] x;
        x = 8'(k + 16 * blk);
        return {x, ~x};
    endfunction

    function automatic logic [DW-1:0] lookup(input int k);
        for (int n = 0; n < N2; n++) begin
            if (tbl[n].in0_idx == k) return m_feed0[n];
            if (tbl[n].in1_idx == k) return m_feed1[n];
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_armed   = 1'b0;
        m_cnt     = 0;
        have_last = 1'b0;
        sb.delete();
    endtask

    // Frames accepted pairs into blocks exactly as the stream defines them and
    // queues the natural-order result once a block completes.
    task automatic model_accept(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input bit is_real);
        exp_t e;
        if (!m_armed) begin
            if (!s) return;
            m_armed = 1'b1;
            m_cnt   = 0;
        end else if (RESYNC && s && m_cnt != 0) begin
            sb.delete();
            m_cnt = 0;
        end
        if (m_cnt == 0) m_real = is_real;
        m_feed0[m_cnt] = a;
        m_feed1[m_cnt] = b;
        m_cnt++;
        if (m_cnt == N2) begin
            m_cnt = 0;
            if (m_real) begin
                for (int m = 0; m < N2; m++) begin
                    e.o0 = lookup(tbl[m].out0_idx);
                    e.o1 = lookup(tbl[m].out1_idx);
                    e.s  = (m == 0);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (err) err_pulses++;
        if (ce) begin
            if (valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out0", 32'(out0), 32'(e.o0));
                    check("out1", 32'(out1), 32'(e.o1));
                    check("osync", 32'(osync), 32'(e.s));
                    last_exp  = e;
                    have_last = 1'b1;
                end else begin
                    have_last = 1'b0;
                end
            end
        end else if (valid && have_last) begin
            check("hold_out0", 32'(out0), 32'(last_exp.o0));
            check("hold_out1", 32'(out1), 32'(last_exp.o1));
            check("hold_sync", 32'(osync), 32'(last_exp.s));
        end
    endtask

    task automatic step(input logic c, input logic s, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input bit is_real);
        ce   = c;
        sync = s;
        in0  = a;
        in1  = b;
        if (c) model_accept(s, a, b, is_real);
        tick();
    endtask

    task automatic idles(input bit rand_ce);
        if (rand_ce) begin
            for (int j = 0; j < 3 && $urandom_range(0, 1) == 1; j++)
                step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'b0);
        end
    endtask

    task automatic feed(input int blk, input int first, input int last_n, input bit with_sync,
                        input bit rand_ce);
        for (int n = first; n <= last_n; n++) begin
            idles(rand_ce);
            step(1'b1, with_sync && (n == 0), val(blk, tbl[n].in0_idx), val(blk, tbl[n].in1_idx), 1'b1);
        end
    endtask

    task automatic flush(input int cnt, input bit rand_ce);
        for (int i = 0; i < cnt; i++) begin
            idles(rand_ce);
            step(1'b1, 1'b0, {8'hEE, 8'(i)}, {8'hDD, 8'(i)}, 1'b0);
        end
    endtask

    task automatic do_reset();
        ce   = 1'b0;
        sync = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        void'($urandom(32'd11));
        // Hand-derived 16-point reorder: step n carries (br(2n), br(2n)+8), output m is (2m, 2m+1).
        tbl[0] = '{0, 8,  0,  1};
        tbl[1] = '{4, 12, 2,  3};
        tbl[2] = '{2, 10, 4,  5};
        tbl[3] = '{6, 14, 6,  7};
        tbl[4] = '{1, 9,  8,  9};
        tbl[5] = '{5, 13, 10, 11};
        tbl[6] = '{3, 11, 12, 13};
        tbl[7] = '{7, 15, 14, 15};

        #2 rst = 1'b1;
        #10;
        check("rst_out0", 32'(out0), 32'h0);
        check("rst_out1", 32'(out1), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_sync", 32'(osync), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ce without sync after reset must not arm the block.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, val(9, i), val(9, i + 8), 1'b0);
            check("idle_valid", 32'(valid), 32'h0);
            check("idle_out0", 32'(out0), 32'h0);
        end

        // Aligned stream, three distinct blocks back to back.
        for (int n = 0; n < N2; n++) begin
            step(1'b1, n == 0, val(0, tbl[n].in0_idx), val(0, tbl[n].in1_idx), 1'b1);
            check("fill_valid", 32'(valid), 32'h0);
        end
        step(1'b1, 1'b1, val(1, tbl[0].in0_idx), val(1, tbl[0].in1_idx), 1'b1);
        check("latency_valid", 32'(valid), 32'h1);
        check("latency_sync", 32'(osync), 32'h1);
        feed(1, 1, N2 - 1, 1'b1, 1'b0);
        feed(2, 0, N2 - 1, 1'b1, 1'b0);
        flush(N2, 1'b0);
        check("drain_stream", 32'(sb.size()), 32'h0);

        // Random 50% ce: same data order, outputs hold through idle cycles.
        do_reset();
        feed(3, 0, N2 - 1, 1'b1, 1'b1);
        feed(4, 0, N2 - 1, 1'b1, 1'b1);
        feed(5, 0, N2 - 1, 1'b1, 1'b1);
        flush(N2, 1'b1);
        check("drain_random", 32'(sb.size()), 32'h0);

        // Asynchronous reset in the middle of RUN.
        do_reset();
        feed(6, 0, N2 - 1, 1'b1, 1'b0);
        feed(7, 0, 3, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out0", 32'(out0), 32'h0);
        check("midrst_out1", 32'(out1), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        feed(8, 0, N2 - 1, 1'b1, 1'b0);
        flush(N2, 1'b0);
        check("drain_midrst", 32'(sb.size()), 32'h0);

        // Stray syncs: one during FILL (step 5), one during RUN (step 3).
        do_reset();
        err_pulses = 0;
        feed(9, 0, 4, 1'b1, 1'b0);
        feed(10, 0, N2 - 1, 1'b1, 1'b0);
        feed(11, 0, N2 - 1, 1'b1, 1'b0);
        feed(12, 0, 2, 1'b1, 1'b0);
        step(1'b1, 1'b1, val(13, tbl[0].in0_idx), val(13, tbl[0].in1_idx), 1'b1);
        check("resync_valid", 32'(valid), RESYNC ? 32'h0 : 32'h1);
        feed(13, 1, N2 - 1, 1'b1, 1'b0);
        flush(2 * N2, 1'b0);
        check("err_pulses", 32'(err_pulses), RESYNC ? 32'd2 : 32'd0);
        check("drain_resync", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
